// File: rtl/complex_mac_stream.sv
// complex_mac_stream: pipelined complex multiply / frame accumulate with
// round, scale and saturate, feeding a credit-controlled FWFT output FIFO.
module complex_mac_stream #(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 32,
  parameter int ACC_WIDTH         = 48,
  parameter int SHIFT             = 15,
  parameter int ROUND_MODE        = 0,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                               aclk,
  input  logic                                               areset,
  input  logic [16*((2*OPERAND_WIDTH_A+15)/16)-1:0]          s_axis_a_tdata,
  input  logic                                               s_axis_a_tvalid,
  input  logic                                               s_axis_a_tlast,
  output logic                                               s_axis_a_tready,
  input  logic [16*((2*OPERAND_WIDTH_B+15)/16)-1:0]          s_axis_b_tdata,
  input  logic                                               s_axis_b_tvalid,
  output logic                                               s_axis_b_tready,
  input  logic                                               conj_b,
  input  logic                                               acc_en,
  output logic [16*((2*OPERAND_WIDTH_OUT+15)/16)-1:0]        m_axis_dout_tdata,
  output logic                                               m_axis_dout_tvalid,
  output logic                                               m_axis_dout_tlast,
  output logic                                               m_axis_dout_tuser,
  input  logic                                               m_axis_dout_tready
);

  localparam int WA     = OPERAND_WIDTH_A;
  localparam int WB     = OPERAND_WIDTH_B;
  localparam int WO     = OPERAND_WIDTH_OUT;
  localparam int AW     = ACC_WIDTH;
  localparam int PW     = WA + WB;
  localparam int SW     = PW + 1;
  localparam int A_TW   = 16 * ((2 * WA + 15) / 16);
  localparam int B_TW   = 16 * ((2 * WB + 15) / 16);
  localparam int O_TW   = 16 * ((2 * WO + 15) / 16);
  localparam int O_HW   = O_TW / 2;
  localparam int PTRW   = $clog2(FIFO_DEPTH);
  localparam int CW     = PTRW + 1;
  localparam int WORD_W = 2 * WO + 2;

  localparam logic signed [AW:0] RND =
    (ROUND_MODE == 1) ? ((AW + 1)'(1) << (SHIFT - 1)) : '0;

  typedef enum logic {FIRST, IN_FRAME} frame_state_t;

  frame_state_t state, state_nxt;
  logic         frame_mode;
  logic         beat_acc;
  logic         ready;
  logic         accept;

  logic [CW-1:0] inflight;
  logic [CW-1:0] mem_cnt;
  logic [CW-1:0] fifo_count;

  // S1..S4 pipeline registers
  logic                 s1_valid, s1_conj, s1_acc, s1_last;
  logic signed [WA-1:0] s1_ar, s1_ai;
  logic signed [WB-1:0] s1_br, s1_bi;
  logic                 s2_valid, s2_conj, s2_acc, s2_last;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ir, s2_ri;
  logic                 s3_valid, s3_acc, s3_last;
  logic signed [SW-1:0] s3_pr, s3_pi;
  logic signed [AW-1:0] acc_r, acc_i;
  logic signed [AW-1:0] v_r, v_i;
  logic [WO:0]          rs_r, rs_i;
  logic                 s4_valid, s4_emit;
  logic [WORD_W-1:0]    s4_word;

  // Output FIFO
  logic [WORD_W-1:0]    mem [FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr, rd_ptr;
  logic                 head_valid;
  logic [WORD_W-1:0]    head_data;
  logic                 fifo_wr, fifo_ld, fifo_rd;

  function automatic logic [WO:0] round_sat(input logic signed [AW-1:0] v);
    logic signed [AW:0] s;
    logic signed [AW:0] r;
    s = (AW + 1)'(v) + RND;
    r = s >>> SHIFT;
    if ((&r[AW:WO-1]) || (~|r[AW:WO-1])) begin
      round_sat = {1'b0, r[WO-1:0]};
    end else begin
      round_sat = {1'b1, r[AW], {(WO-1){~r[AW]}}};
    end
  endfunction

  assign fifo_count      = mem_cnt + CW'(head_valid);
  assign ready           = ~areset &
                           (({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign s_axis_a_tready = ready;
  assign s_axis_b_tready = ready;
  assign accept          = s_axis_a_tvalid & s_axis_b_tvalid & ready;

  // Frame tracking: mode is taken from acc_en on the first beat, then held
  always_comb begin
    state_nxt = state;
    beat_acc  = frame_mode;
    if (state == FIRST) begin
      beat_acc = acc_en;
    end
    if (accept) begin
      state_nxt = s_axis_a_tlast ? FIRST : IN_FRAME;
    end
  end

  // Frame state register and latched frame mode
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= FIRST;
      frame_mode <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && state == FIRST) begin
        frame_mode <= acc_en;
      end
    end
  end

  // Credits held by beats still inside S1..S4
  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(s4_valid);
    end
  end

  // S1: capture operands and per-beat flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    s1_ar   <= s_axis_a_tdata[WA-1:0];
    s1_ai   <= s_axis_a_tdata[A_TW/2 +: WA];
    s1_br   <= s_axis_b_tdata[WB-1:0];
    s1_bi   <= s_axis_b_tdata[B_TW/2 +: WB];
    s1_conj <= conj_b;
    s1_acc  <= beat_acc;
    s1_last <= s_axis_a_tlast;
  end

  // S2: four full-precision partial products
  always_ff @(posedge aclk) begin
    if (areset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    s2_rr   <= PW'(s1_ar) * PW'(s1_br);
    s2_ii   <= PW'(s1_ai) * PW'(s1_bi);
    s2_ir   <= PW'(s1_ai) * PW'(s1_br);
    s2_ri   <= PW'(s1_ar) * PW'(s1_bi);
    s2_conj <= s1_conj;
    s2_acc  <= s1_acc;
    s2_last <= s1_last;
  end

  // S3: combine products; conj(b) flips the sign of the bi terms
  always_ff @(posedge aclk) begin
    if (areset) begin
      s3_valid <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
    end
    if (s2_conj) begin
      s3_pr <= SW'(s2_rr) + SW'(s2_ii);
      s3_pi <= SW'(s2_ir) - SW'(s2_ri);
    end else begin
      s3_pr <= SW'(s2_rr) - SW'(s2_ii);
      s3_pi <= SW'(s2_ir) + SW'(s2_ri);
    end
    s3_acc  <= s2_acc;
    s3_last <= s2_last;
  end

  // S4 datapath: optional accumulate, then round/shift/saturate
  always_comb begin
    v_r = AW'(s3_pr);
    v_i = AW'(s3_pi);
    if (s3_acc) begin
      v_r = acc_r + AW'(s3_pr);
      v_i = acc_i + AW'(s3_pi);
    end
    rs_r = round_sat(v_r);
    rs_i = round_sat(v_i);
  end

  // S4 register and accumulator; non-last accumulate beats are not emitted
  always_ff @(posedge aclk) begin
    if (areset) begin
      s4_valid <= 1'b0;
      acc_r    <= '0;
      acc_i    <= '0;
    end else begin
      s4_valid <= s3_valid;
      if (s3_valid && s3_acc) begin
        acc_r <= s3_last ? '0 : v_r;
        acc_i <= s3_last ? '0 : v_i;
      end
    end
    s4_emit <= ~s3_acc | s3_last;
    s4_word <= {rs_r[WO] | rs_i[WO], s3_last, rs_i[WO-1:0], rs_r[WO-1:0]};
  end

  assign fifo_wr = s4_valid & s4_emit;
  assign fifo_rd = head_valid & m_axis_dout_tready;
  assign fifo_ld = (mem_cnt != '0) & (~head_valid | fifo_rd);

  // FIFO storage; credits guarantee space for every write
  always_ff @(posedge aclk) begin
    if (fifo_wr && !areset) begin
      mem[wr_ptr] <= s4_word;
    end
  end

  // FIFO pointers and registered head, refilled as soon as it drains
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (fifo_ld) begin
        head_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTRW'(1);
      end
      if (fifo_ld) begin
        head_valid <= 1'b1;
      end else if (fifo_rd) begin
        head_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(fifo_wr) - CW'(fifo_ld);
    end
  end

  assign m_axis_dout_tvalid = head_valid;
  assign m_axis_dout_tlast  = head_data[2*WO];
  assign m_axis_dout_tuser  = head_data[2*WO+1];
  assign m_axis_dout_tdata  = {O_HW'($signed(head_data[2*WO-1:WO])),
                               O_HW'($signed(head_data[WO-1:0]))};

endmodule

// File: tb/tb_complex_mac_stream.sv
// Directed bench for complex_mac_stream with 16-bit outputs and rounding.
module tb_complex_mac_stream;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_a_tdata = '0;
  logic        s_axis_a_tvalid = 1'b0;
  logic        s_axis_a_tlast = 1'b0;
  logic        s_axis_a_tready;
  logic [31:0] s_axis_b_tdata = '0;
  logic        s_axis_b_tvalid = 1'b0;
  logic        s_axis_b_tready;
  logic        conj_b = 1'b0;
  logic        acc_en = 1'b0;
  logic [31:0] m_axis_dout_tdata;
  logic        m_axis_dout_tvalid;
  logic        m_axis_dout_tlast;
  logic        m_axis_dout_tuser;
  logic        m_axis_dout_tready = 1'b1;

  complex_mac_stream #(
    .OPERAND_WIDTH_A(16),
    .OPERAND_WIDTH_B(16),
    .OPERAND_WIDTH_OUT(16),
    .ACC_WIDTH(48),
    .SHIFT(15),
    .ROUND_MODE(1),
    .FIFO_DEPTH(8)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_a_tdata(s_axis_a_tdata),
    .s_axis_a_tvalid(s_axis_a_tvalid),
    .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_a_tready(s_axis_a_tready),
    .s_axis_b_tdata(s_axis_b_tdata),
    .s_axis_b_tvalid(s_axis_b_tvalid),
    .s_axis_b_tready(s_axis_b_tready),
    .conj_b(conj_b),
    .acc_en(acc_en),
    .m_axis_dout_tdata(m_axis_dout_tdata),
    .m_axis_dout_tvalid(m_axis_dout_tvalid),
    .m_axis_dout_tlast(m_axis_dout_tlast),
    .m_axis_dout_tuser(m_axis_dout_tuser),
    .m_axis_dout_tready(m_axis_dout_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    logic        cj;
    logic [15:0] er, ei;
    logic        eu;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          cyc;
  } out_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  out_t got_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Record every output handshake; inputs are stable around the negedge
  always @(negedge aclk) begin
    if (m_axis_dout_tvalid && m_axis_dout_tready) begin
      got_q.push_back('{m_axis_dout_tdata, m_axis_dout_tlast, m_axis_dout_tuser, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ar, ai, br, bi, input logic cj, ae, lst);
    int n;
    s_axis_a_tdata  = {ai, ar};
    s_axis_b_tdata  = {bi, br};
    conj_b          = cj;
    acc_en          = ae;
    s_axis_a_tlast  = lst;
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    n = 0;
    while (!s_axis_a_tready && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
    end else begin
      @(posedge aclk); #1;
      acc_cyc = cyc;
    end
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 100) begin
      @(posedge aclk); #1;
      t++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic check_beat(input string name, input logic [31:0] ed, input logic el, eu);
    out_t o;
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no output beat expected data %0h", name, ed);
    end else begin
      o = got_q.pop_front();
      chk({name, "_data"}, 64'(o.data), 64'(ed));
      chk({name, "_last"}, 64'(o.last), 64'(el));
      chk({name, "_user"}, 64'(o.user), 64'(eu));
    end
  endtask

  task automatic do_reset();
    areset          = 1'b1;
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    #1;
    chk("ready_after_reset", 64'({s_axis_a_tready, s_axis_b_tready}), 64'(2'b11));
  endtask

  initial begin
    int k;
    int acc_cnt;
    int t;
    int first_cyc;
    logic r;

    vecs[0]  = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0};
    vecs[1]  = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 16'hE000, 16'h0000, 1'b0};
    vecs[2]  = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 16'h2000, 16'h0000, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h8001, 16'h0000, 1'b0};
    vecs[5]  = '{16'h0000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 16'h7FFF, 1'b1};
    vecs[6]  = '{16'h1000, 16'h2000, 16'h3000, 16'h0800, 1'b0, 16'h0400, 16'h0D00, 1'b0};
    vecs[7]  = '{16'h1000, 16'h2000, 16'h3000, 16'h0800, 1'b1, 16'h0800, 16'h0B00, 1'b0};
    vecs[8]  = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{16'hC000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'hE000, 16'h0000, 1'b0};

    // Reset state
    idle(3);
    chk("rst_tvalid", 64'(m_axis_dout_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_dout_tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis_dout_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_dout_tuser), 64'd0);
    chk("rst_a_tready", 64'(s_axis_a_tready), 64'd0);
    chk("rst_b_tready", 64'(s_axis_b_tready), 64'd0);
    areset = 1'b0;
    #1;
    chk("ready_after_release", 64'({s_axis_a_tready, s_axis_b_tready}), 64'(2'b11));

    // Single-beat product vectors
    for (int i = 0; i < NV; i++) begin
      got_q.delete();
      send(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].cj, 1'b0, 1'b1);
      wait_out(1);
      if (i == 0 && got_q.size() > 0) begin
        chk("latency", 64'(got_q[0].cyc - acc_cyc), 64'd5);
      end
      check_beat("vec", {vecs[i].ei, vecs[i].er}, 1'b1, vecs[i].eu);
    end

    // Accumulate frame of three beats, acc_en only on the first
    got_q.delete();
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b1);
    wait_out(1);
    idle(8);
    chk("acc_count", 64'(got_q.size()), 64'd1);
    check_beat("acc3", 32'h0000_3000, 1'b1, 1'b0);

    // Next accumulate frame starts from zero
    got_q.delete();
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_out(1);
    check_beat("acc1", 32'h0000_1000, 1'b1, 1'b0);

    // Two-beat non-accumulate frame emits both beats
    got_q.delete();
    send(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b1);
    wait_out(2);
    idle(4);
    chk("pass2_count", 64'(got_q.size()), 64'd2);
    check_beat("pass2_b0", 32'h0000_2000, 1'b0, 1'b0);
    check_beat("pass2_b1", 32'h0000_1000, 1'b1, 1'b0);

    // Back-pressure: FIFO_DEPTH beats accepted, then ready drops
    got_q.delete();
    m_axis_dout_tready = 1'b0;
    k       = 1;
    acc_cnt = 0;
    s_axis_a_tdata  = {16'h0000, 16'(2 * k)};
    s_axis_b_tdata  = {16'h0000, 16'h4000};
    conj_b          = 1'b0;
    acc_en          = 1'b0;
    s_axis_a_tlast  = 1'b1;
    s_axis_a_tvalid = 1'b1;
    s_axis_b_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      r = s_axis_a_tready;
      @(posedge aclk); #1;
      if (r) begin
        acc_cnt++;
        k++;
        s_axis_a_tdata = {16'h0000, 16'(2 * k)};
      end
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd8);
    chk("bp_ready_low", 64'(s_axis_a_tready), 64'd0);
    chk("bp_hold_valid", 64'(m_axis_dout_tvalid), 64'd1);
    chk("bp_hold_data", 64'(m_axis_dout_tdata), 64'h0000_0001);
    m_axis_dout_tready = 1'b1;
    t = 0;
    while (k <= 16 && t < 200) begin
      r = s_axis_a_tready;
      @(posedge aclk); #1;
      t++;
      if (r) begin
        k++;
        s_axis_a_tdata = {16'h0000, 16'(2 * k)};
      end
    end
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
    wait_out(16);
    idle(8);
    chk("bp_count", 64'(got_q.size()), 64'd16);
    first_cyc = (got_q.size() > 0) ? got_q[0].cyc : 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8 && got_q.size() > 0) begin
        chk("bp_no_gap", 64'(got_q[0].cyc - first_cyc), 64'(i));
      end
      check_beat("bp_beat", 32'(i + 1), 1'b1, 1'b0);
    end

    // Reset while a beat is inside the pipeline discards it
    got_q.delete();
    send(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    do_reset();
    idle(12);
    chk("pipe_reset_discard", 64'(got_q.size()), 64'd0);

    // Reset mid accumulate frame: next frame yields only its own product
    got_q.delete();
    send(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle(6);
    do_reset();
    send(16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_out(1);
    idle(8);
    chk("frame_reset_count", 64'(got_q.size()), 64'd1);
    check_beat("frame_reset", 32'h0000_1000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
